// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   INST_W        : instruction / address width
//   NOP           : value driven on if_inst while nothing is valid
//   fetch_state_t : RUN (normal fetching) / FLUSH (discarding stale responses)
//   fetch_entry_t : one buffered fetch, {pc, inst}
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int INST_W = 32;
   localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [INST_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small circular FIFO of fetch_entry_t records. Used both as the instruction
// buffer feeding decode and as the queue of PCs whose responses are pending.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset (pointers/count only)
//   clear           : synchronous flush of all entries
//   push, wdata     : write one entry
//   pop             : release the head entry
//   rdata           : head entry (meaningful only while count != 0)
//   count           : number of entries held
// Simultaneous push and pop are allowed, including when full.
// -----------------------------------------------------------------------------
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          push,
   input  fetch_entry_t  wdata,
   input  logic          pop,
   output fetch_entry_t  rdata,
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          wr_en;
   logic          rd_en;

   // Pointer increment that also works for non-power-of-two depths.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Overflow/underflow guards: writes into a full FIFO only when the head
   // leaves in the same cycle; pops of an empty FIFO are ignored.
   assign wr_en = push && ((count != CW'(DEPTH)) || pop);
   assign rd_en = pop && (count != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= next_ptr(wr_ptr);
         if (rd_en) rd_ptr <= next_ptr(rd_ptr);
         count <= count + CW'(wr_en) - CW'(rd_en);
      end
   end

   // Storage is not reset; the count qualifies every read.
   always_ff @(posedge clk) begin
      if (wr_en && !clear) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage. Owns the fetch PC, issues word-aligned requests to
// instruction memory, buffers in-order variable-latency responses and hands
// {inst, pc, pc+4} to decode. A redirect flushes buffered instructions and
// drops responses that are still in flight.
// Parameters:
//   DEPTH     : buffer entries == max outstanding-plus-buffered fetches
//   RESET_PC  : first fetch address after reset
// Ports:
//   clk, reset (async, active-low)
//   redirect, redirect_pc           : taken branch / jump, new target
//   imem_req, imem_addr, imem_ready : request handshake to memory
//   imem_rvalid, imem_rdata         : in-order response from memory
//   if_valid, if_inst, if_pc, if_pc4, id_ready : handshake to decode
// -----------------------------------------------------------------------------
module inst_fetch
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc4,
   input  logic        id_ready
);

   localparam int CW = $clog2(DEPTH + 1);

   fetch_state_t  state;
   logic          started;
   logic [31:0]   fetch_pc;
   logic [CW-1:0] out_cnt;
   logic [CW-1:0] buf_cnt;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] out_next;
   logic [CW:0]   credit_use;
   logic          credit_ok;
   logic          accept;
   logic          rsp;
   logic          pop;
   logic          push;
   fetch_entry_t  pcq_wdata;
   fetch_entry_t  pcq_head;
   fetch_entry_t  buf_wdata;
   fetch_entry_t  buf_head;
   logic          unused_bits;

   // A response with nothing outstanding is a memory protocol error; it is
   // ignored so the counters cannot underflow.
   assign rsp      = imem_rvalid && (out_cnt != '0);
   assign if_valid = (buf_cnt != '0);
   assign pop      = if_valid && id_ready && !redirect;

   // Credit: every outstanding request owns a buffer slot, so the buffer can
   // never overflow. A pop this cycle frees a slot for a same-cycle request.
   assign credit_use = {1'b0, out_cnt} + {1'b0, buf_cnt} - (CW + 1)'(pop);
   assign credit_ok  = credit_use < (CW + 1)'(DEPTH);

   // 'started' keeps the request low until the first edge after reset release.
   assign imem_req  = started && (state == RUN) && credit_ok;
   assign imem_addr = fetch_pc;
   assign accept    = imem_req && imem_ready;

   // Responses are only kept in RUN and never in a redirect cycle.
   assign push     = rsp && (state == RUN) && !redirect;
   assign out_next = out_cnt + CW'(accept) - CW'(rsp);

   assign pcq_wdata = '{pc: fetch_pc, inst: NOP};
   assign buf_wdata = '{pc: pcq_head.pc, inst: imem_rdata};

   // The in-flight PC queue's occupancy is the outstanding-request count.
   fetch_fifo #(.DEPTH(DEPTH)) u_pcq (
      .clk   (clk),
      .reset (reset),
      .clear (1'b0),
      .push  (accept),
      .wdata (pcq_wdata),
      .pop   (rsp),
      .rdata (pcq_head),
      .count (out_cnt)
   );

   fetch_fifo #(.DEPTH(DEPTH)) u_ibuf (
      .clk   (clk),
      .reset (reset),
      .clear (redirect),
      .push  (push),
      .wdata (buf_wdata),
      .pop   (pop),
      .rdata (buf_head),
      .count (buf_cnt)
   );

   // Data outputs read as zero whenever nothing is valid.
   assign if_pc   = if_valid ? buf_head.pc : '0;
   assign if_inst = if_valid ? buf_head.inst : NOP;
   assign if_pc4  = if_valid ? (buf_head.pc + 32'd4) : '0;

   assign unused_bits = ^{redirect_pc[1:0], pcq_head.inst};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= RUN;
         started  <= 1'b0;
         fetch_pc <= RESET_PC;
         drop_cnt <= '0;
      end else begin
         started <= 1'b1;
         if (redirect) begin
            // Everything still in flight after this edge is stale, including
            // a request accepted in this very cycle.
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            drop_cnt <= out_next;
            state    <= (out_next != '0) ? FLUSH : RUN;
         end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if ((state == FLUSH) && rsp) begin
               drop_cnt <= drop_cnt - 1'b1;
               if (drop_cnt == CW'(1)) state <= RUN;
            end
         end
      end
   end

   assert property (@(posedge clk) disable iff (!reset)
                    !(imem_rvalid && (out_cnt == '0)));

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

   logic        clk;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [31:0] if_pc4;
   logic        id_ready;

   int total;
   int bad;
   int ecnt;
   int lat;

   logic [31:0] mq_addr [$];
   int          mq_due  [$];

   typedef struct {
      logic        idr;
      logic        imr;
      logic        ereq;
      logic [31:0] eaddr;
      logic        ev;
      logic [31:0] epc;
   } vec_t;

   vec_t vt [18];

   inst_fetch #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_inst     (if_inst),
      .if_pc       (if_pc),
      .if_pc4      (if_pc4),
      .id_ready    (id_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drive inputs at the falling edge; the memory model answers the oldest
   // accepted request once its latency has elapsed.
   task automatic drive(input logic idr, input logic imr, input logic rd, input logic [31:0] rpc);
      id_ready    = idr;
      imem_ready  = imr;
      redirect    = rd;
      redirect_pc = rpc;
      if (mq_addr.size() > 0 && mq_due[0] <= ecnt + 1) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(mq_addr[0]);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'hDEAD_BEEF;
      end
      #1;
   endtask

   task automatic step();
      logic        acc;
      logic        rv;
      logic [31:0] a;
      acc = imem_req && imem_ready;
      a   = imem_addr;
      rv  = imem_rvalid;
      @(posedge clk);
      ecnt++;
      if (rv) begin
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
      if (acc) begin
         mq_addr.push_back(a);
         mq_due.push_back(ecnt + lat);
      end
      @(negedge clk);
   endtask

   task automatic row(input string nm, input logic idr, input logic imr, input logic rd,
                      input logic [31:0] rpc, input logic ereq, input logic [31:0] eaddr,
                      input logic ev, input logic [31:0] epc);
      drive(idr, imr, rd, rpc);
      chk({nm, "_req"},   32'(imem_req), 32'(ereq));
      chk({nm, "_addr"},  imem_addr, eaddr);
      chk({nm, "_valid"}, 32'(if_valid), 32'(ev));
      chk({nm, "_pc"},    if_pc,   ev ? epc : 32'h0);
      chk({nm, "_inst"},  if_inst, ev ? mem_word(epc) : 32'h0);
      chk({nm, "_pc4"},   if_pc4,  ev ? (epc + 32'd4) : 32'h0);
      step();
   endtask

   task automatic run_stream(input string nm, input int ncyc, input logic [31:0] start, input int min_n);
      logic [31:0] exp;
      int          n;
      exp = start;
      n   = 0;
      for (int i = 0; i < ncyc; i++) begin
         drive(1'b1, 1'b1, 1'b0, 32'h0);
         if (if_valid) begin
            chk({nm, "_pc"},   if_pc, exp);
            chk({nm, "_inst"}, if_inst, mem_word(exp));
            chk({nm, "_pc4"},  if_pc4, exp + 32'd4);
            exp = exp + 32'd4;
            n++;
         end else begin
            chk({nm, "_idle_pc"},   if_pc, 32'h0);
            chk({nm, "_idle_inst"}, if_inst, 32'h0);
         end
         step();
      end
      chk({nm, "_count_ok"}, 32'(n >= min_n), 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      mq_addr.delete();
      mq_due.delete();
      imem_rvalid = 1'b0;
      redirect    = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      ecnt  = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "simulation did not complete");
   end

   initial begin
      total = 0; bad = 0; ecnt = 0; lat = 1;
      clk = 1'b0; reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      id_ready = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

      //                idr   imr   req   addr           v     pc
      vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
      vt[1]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
      vt[2]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000};
      vt[3]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};
      vt[4]  = '{1'b1, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004};
      vt[5]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008};
      vt[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0014, 1'b1, 32'h0000_000C};
      vt[7]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0014, 1'b1, 32'h0000_000C};
      vt[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0014, 1'b1, 32'h0000_000C};
      vt[9]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0014, 1'b1, 32'h0000_000C};
      vt[10] = '{1'b0, 1'b1, 1'b0, 32'h0000_0014, 1'b1, 32'h0000_000C};
      vt[11] = '{1'b1, 1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_000C};
      vt[12] = '{1'b1, 1'b1, 1'b1, 32'h0000_0018, 1'b1, 32'h0000_0010};
      vt[13] = '{1'b1, 1'b1, 1'b1, 32'h0000_001C, 1'b1, 32'h0000_0014};
      vt[14] = '{1'b1, 1'b0, 1'b1, 32'h0000_0020, 1'b1, 32'h0000_0018};
      vt[15] = '{1'b1, 1'b1, 1'b1, 32'h0000_0020, 1'b1, 32'h0000_001C};
      vt[16] = '{1'b1, 1'b1, 1'b1, 32'h0000_0024, 1'b0, 32'h0000_0000};
      vt[17] = '{1'b1, 1'b1, 1'b1, 32'h0000_0028, 1'b1, 32'h0000_0020};

      // Reset held
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req",   32'(imem_req), 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_addr",  imem_addr, 32'h0);
      chk("rst_pc",    if_pc, 32'h0);
      chk("rst_inst",  if_inst, 32'h0);
      chk("rst_pc4",   if_pc4, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      ecnt  = 0;

      // Streaming, decode stall, memory not ready (L = 1)
      for (int i = 0; i < 18; i++)
         row($sformatf("vec%0d", i), vt[i].idr, vt[i].imr, 1'b0, 32'h0,
             vt[i].ereq, vt[i].eaddr, vt[i].ev, vt[i].epc);

      // L = 3, redirect with two requests outstanding
      do_reset(); lat = 3;
      row("ra0", 1, 1, 0, 32'h0,        0, 32'h0000_0000, 0, 32'h0);
      row("ra1", 1, 1, 0, 32'h0,        1, 32'h0000_0000, 0, 32'h0);
      row("ra2", 1, 1, 0, 32'h0,        1, 32'h0000_0004, 0, 32'h0);
      row("ra3", 1, 1, 1, 32'h0000_0102, 0, 32'h0000_0008, 0, 32'h0);
      row("ra4", 1, 1, 0, 32'h0,        0, 32'h0000_0100, 0, 32'h0);
      row("ra5", 1, 1, 0, 32'h0,        0, 32'h0000_0100, 0, 32'h0);
      row("ra6", 1, 1, 0, 32'h0,        1, 32'h0000_0100, 0, 32'h0);
      row("ra7", 1, 1, 0, 32'h0,        1, 32'h0000_0104, 0, 32'h0);
      row("ra8", 1, 1, 0, 32'h0,        0, 32'h0000_0108, 0, 32'h0);
      row("ra9", 1, 1, 0, 32'h0,        0, 32'h0000_0108, 0, 32'h0);
      row("ra10", 1, 1, 0, 32'h0,       1, 32'h0000_0108, 1, 32'h0000_0100);
      run_stream("sa", 24, 32'h0000_0104, 6);

      // L = 1, redirect in the same cycle as an accept and a response
      do_reset(); lat = 1;
      row("rb0", 1, 1, 0, 32'h0,        0, 32'h0000_0000, 0, 32'h0);
      row("rb1", 1, 1, 0, 32'h0,        1, 32'h0000_0000, 0, 32'h0);
      row("rb2", 1, 1, 1, 32'h0000_0300, 1, 32'h0000_0004, 0, 32'h0);
      row("rb3", 1, 1, 0, 32'h0,        0, 32'h0000_0300, 0, 32'h0);
      row("rb4", 1, 1, 0, 32'h0,        1, 32'h0000_0300, 0, 32'h0);
      row("rb5", 1, 1, 0, 32'h0,        1, 32'h0000_0304, 0, 32'h0);
      row("rb6", 1, 1, 0, 32'h0,        1, 32'h0000_0308, 1, 32'h0000_0300);
      run_stream("sb", 12, 32'h0000_0304, 10);

      // L = 3, second redirect while flushing
      do_reset(); lat = 3;
      row("rc0", 1, 1, 0, 32'h0,        0, 32'h0000_0000, 0, 32'h0);
      row("rc1", 1, 1, 0, 32'h0,        1, 32'h0000_0000, 0, 32'h0);
      row("rc2", 1, 1, 0, 32'h0,        1, 32'h0000_0004, 0, 32'h0);
      row("rc3", 1, 1, 1, 32'h0000_1000, 0, 32'h0000_0008, 0, 32'h0);
      row("rc4", 1, 1, 1, 32'h0000_0200, 0, 32'h0000_1000, 0, 32'h0);
      row("rc5", 1, 1, 0, 32'h0,        0, 32'h0000_0200, 0, 32'h0);
      row("rc6", 1, 1, 0, 32'h0,        1, 32'h0000_0200, 0, 32'h0);
      run_stream("sc", 24, 32'h0000_0200, 4);

      // L = 1, fetch address wraps past the top of memory
      do_reset(); lat = 1;
      row("rd0", 1, 1, 0, 32'h0,        0, 32'h0000_0000, 0, 32'h0);
      row("rd1", 1, 1, 0, 32'h0,        1, 32'h0000_0000, 0, 32'h0);
      row("rd2", 1, 1, 1, 32'hFFFF_FFF9, 1, 32'h0000_0004, 0, 32'h0);
      row("rd3", 1, 1, 0, 32'h0,        0, 32'hFFFF_FFF8, 0, 32'h0);
      row("rd4", 1, 1, 0, 32'h0,        1, 32'hFFFF_FFF8, 0, 32'h0);
      row("rd5", 1, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0);
      row("rd6", 1, 1, 0, 32'h0,        1, 32'h0000_0000, 1, 32'hFFFF_FFF8);
      row("rd7", 1, 1, 0, 32'h0,        1, 32'h0000_0004, 1, 32'hFFFF_FFFC);
      run_stream("sd", 8, 32'h0000_0000, 6);

      // Asynchronous reset between clock edges while streaming
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      chk("pre_areset_valid", 32'(if_valid), 32'd1);
      chk("pre_areset_req",   32'(imem_req), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("areset_req",   32'(imem_req), 32'd0);
      chk("areset_valid", 32'(if_valid), 32'd0);
      chk("areset_pc",    if_pc, 32'h0);
      chk("areset_addr",  imem_addr, 32'h0);
      do_reset(); lat = 1;
      row("re0", 1, 1, 0, 32'h0, 0, 32'h0000_0000, 0, 32'h0);
      row("re1", 1, 1, 0, 32'h0, 1, 32'h0000_0000, 0, 32'h0);
      row("re2", 1, 1, 0, 32'h0, 1, 32'h0000_0004, 0, 32'h0);
      run_stream("se", 10, 32'h0000_0000, 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage sitting directly downstream of the PC logic. It owns the fetch address, issues word-aligned requests to instruction memory over a request/ready handshake, and absorbs variable-latency in-order responses in a small FIFO. It presents instruction, PC and PC+4 to decode with a valid/ready handshake. A taken-branch redirect flushes the FIFO and discards responses still in flight.

## Interface
- DEPTH, 2, fetch FIFO entries and maximum outstanding-plus-buffered fetches (>=2 for full throughput)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- redirect  in  1  taken branch/jump this cycle
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid; responses return in request order, >=1 cycle after acceptance
- imem_rdata  in  32  instruction word
- if_valid  out  1  decode output valid
- if_inst  out  32  instruction
- if_pc  out  32  address of if_inst
- if_pc4  out  32  if_pc + 4
- id_ready  in  1  decode accepts this cycle

## Operation
- Registers: fetch_pc, outstanding count, FIFO of {pc, inst}, drop_cnt, state.
- States: RUN (normal), FLUSH (drop_cnt > 0, discarding stale responses).
- Accept = imem_req && imem_ready; pop = if_valid && id_ready && !redirect.
- RUN issue rule: imem_req = 1 when outstanding + fifo_count - pop < DEPTH. On accept, fetch_pc <= fetch_pc + 4 (32-bit wrap; 0xFFFF_FFFC -> 0), and the PC is pushed onto an in-flight PC queue.
- Response: imem_rvalid in RUN pushes {oldest in-flight pc, imem_rdata} into the FIFO; outstanding decrements. The credit rule guarantees the FIFO never overflows. An rvalid with outstanding == 0 is a protocol error: assert in simulation, ignore in RTL.
- Redirect (highest priority, any state):
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - FIFO is cleared; if_valid = 0 next cycle.
  - drop_cnt <= outstanding + accept - imem_rvalid, including any request accepted in the same cycle.
  - state <= FLUSH if that value is > 0, else RUN.
- FLUSH: imem_req = 0; each imem_rvalid is discarded and decrements drop_cnt and outstanding. At drop_cnt reaching 0, state returns to RUN and requests resume the next cycle.
- A redirect during FLUSH reloads drop_cnt with the formula above and keeps only the latest redirect_pc.
- if_pc4 = if_pc + 4, combinational from the FIFO head.

## Timing
- Reset (async assert):
  - imem_req = 0, if_valid = 0, fetch_pc = RESET_PC, FIFO and counters cleared, state = RUN.
  - All data outputs are 0 while if_valid = 0.
- First request is on the first clk edge after reset deasserts (imem_req = 1, imem_addr = RESET_PC).
- Latency: accept at cycle N, rvalid at N+L (L >= 1), if_valid at N+L+1. There is no bypass from imem_rdata to if_inst.
- Throughput: with L = 1, imem_ready = 1, id_ready = 1 and DEPTH >= 2, one instruction per cycle is sustained.
- imem_req/imem_addr are stable until accepted, except that a redirect may change imem_addr the following cycle.
- if_valid/if_inst/if_pc are held while id_ready = 0.
- Reset mid-operation discards everything. Any responses arriving after reset release are the memory's problem; the memory must be reset together with this block.

## Structure
- Package fetch_pkg holds:
  - INST_W = 32, NOP = 32'h0000_0000;
  - fetch_state_t enum {RUN, FLUSH};
  - fetch_entry_t struct {pc, inst}.
- Sub-module fetch_fifo (parameter DEPTH, synchronous clear, push/pop/count, entries of fetch_entry_t). The same circular structure is reused for the in-flight PC queue.

## Test plan
- Reset hold then release, memory L = 1, ready = 1 -> addresses 0, 4, 8, 12 on consecutive cycles; if_valid from cycle 3 with if_pc 0, 4, 8 and if_pc4 = if_pc + 4.
- id_ready = 0 for 5 cycles -> at most DEPTH = 2 fetches outstanding/buffered, imem_req drops, outputs held; resumes with no lost or duplicated PC.
- L = 3, redirect to 0x0000_0102 with 2 outstanding -> those 2 rvalids discarded; next imem_addr = 0x0000_0100; first if_pc after the redirect = 0x100.
- Redirect coincident with accept and with rvalid -> drop_cnt equals outstanding + 1 - 1; no stale instruction reaches decode.
- Second redirect (0x200) during FLUSH -> only 0x200 stream appears; fetch_pc wraps from 0xFFFF_FFFC to 0.
- Async reset asserted mid-stream (between edges) -> imem_req and if_valid drop immediately; restart at RESET_PC.
